// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RISC-V control unit: FSM states, opcodes,
// instruction classes and ALU operation selects.
package riscv_ctrl_pkg;

    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StDecode    = 3'd1,
        StExecute   = 3'd2,
        StMemory    = 3'd3,
        StWriteback = 3'd4
    } state_e;

    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpIalu   = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;

    typedef enum logic [2:0] {
        ClsR      = 3'd0,
        ClsLoad   = 3'd1,
        ClsStore  = 3'd2,
        ClsIalu   = 3'd3,
        ClsBranch = 3'd4,
        ClsJal    = 3'd5,
        ClsJalr   = 3'd6
    } iclass_e;

    localparam logic [1:0] AluAdd    = 2'b00;
    localparam logic [1:0] AluBranch = 2'b01;
    localparam logic [1:0] AluFunct  = 2'b10;

endpackage

// File: rtl/opcode_classifier.sv
// Maps a 7-bit RV32 major opcode onto an instruction class; unknown opcodes
// raise illegal and report class R, which the FSM never acts on.
module opcode_classifier
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    output logic [2:0] iclass,
    output logic       illegal
);

    always_comb begin
        iclass  = ClsR;
        illegal = 1'b0;
        case (opcode)
            OpR:      iclass = ClsR;
            OpLoad:   iclass = ClsLoad;
            OpStore:  iclass = ClsStore;
            OpIalu:   iclass = ClsIalu;
            OpBranch: iclass = ClsBranch;
            OpJal:    iclass = ClsJal;
            OpJalr:   iclass = ClsJalr;
            default:  illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM with memory wait timeout and retire counter.
// Outputs never see opcode combinationally, so illegal is a registered pulse.
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                mem_we,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_src,
    output logic                alu_src,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                retire,
    output logic                illegal,
    output logic                bus_error,
    output logic [1:0]          alu_op,
    output logic [2:0]          state,
    output logic [RETIRE_W-1:0] retired
);

    localparam logic [7:0] WaitLimit = 8'(MEM_TIMEOUT - 1);

    state_e              state_q, state_d;
    iclass_e             class_q;
    logic [7:0]          wait_q;
    logic                backoff_q;
    logic                illegal_q;
    logic [RETIRE_W-1:0] retired_q;

    logic [2:0] dec_class;
    logic       dec_illegal;
    logic       at_limit;

    opcode_classifier u_classifier (
        .opcode  (opcode),
        .iclass  (dec_class),
        .illegal (dec_illegal)
    );

    assign at_limit = (wait_q == WaitLimit) && !mem_ready;

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        retire     = 1'b0;
        bus_error  = 1'b0;
        alu_op     = AluAdd;
        case (state_q)
            StFetch: begin
                // One idle cycle after a timeout before re-requesting
                if (!backoff_q) begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = StDecode;
                    end else if (at_limit) begin
                        bus_error = 1'b1;
                    end
                end
            end
            StDecode: begin
                state_d = dec_illegal ? StFetch : StExecute;
            end
            StExecute: begin
                case (class_q)
                    ClsR: begin
                        alu_op  = AluFunct;
                        state_d = StWriteback;
                    end
                    ClsIalu: begin
                        alu_src = 1'b1;
                        state_d = StWriteback;
                    end
                    ClsLoad, ClsStore: begin
                        alu_src = 1'b1;
                        state_d = StMemory;
                    end
                    ClsBranch: begin
                        alu_op   = AluBranch;
                        pc_write = zero;
                        pc_src   = 1'b1;
                        retire   = 1'b1;
                        state_d  = StFetch;
                    end
                    ClsJal, ClsJalr: begin
                        alu_src  = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = 1'b1;
                        state_d  = StWriteback;
                    end
                    default: state_d = StFetch;
                endcase
            end
            StMemory: begin
                mem_req = 1'b1;
                mem_we  = (class_q == ClsStore);
                if (mem_ready) begin
                    if (class_q == ClsStore) begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWriteback;
                    end
                end else if (at_limit) begin
                    bus_error = 1'b1;
                    state_d   = StFetch;
                end
            end
            StWriteback: begin
                reg_write  = 1'b1;
                mem_to_reg = (class_q == ClsLoad);
                retire     = 1'b1;
                state_d    = StFetch;
            end
            default: state_d = StFetch;
        endcase
        if (reset) begin
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            pc_src     = 1'b0;
            alu_src    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            retire     = 1'b0;
            bus_error  = 1'b0;
            alu_op     = AluAdd;
        end
    end

    assign illegal = illegal_q & ~reset;
    assign state   = reset ? StFetch : state_q;
    assign retired = reset ? '0 : retired_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StFetch;
            class_q   <= ClsR;
            wait_q    <= '0;
            backoff_q <= 1'b0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            backoff_q <= bus_error;
            illegal_q <= (state_q == StDecode) && dec_illegal;
            if (state_q == StDecode) begin
                class_q <= iclass_e'(dec_class);
            end
            // Clearing on every state change covers entry into FETCH and MEMORY
            if ((state_d != state_q) || bus_error) begin
                wait_q <= '0;
            end else if (mem_req && !mem_ready) begin
                wait_q <= wait_q + 8'd1;
            end
            if (retire) begin
                retired_q <= retired_q + RETIRE_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: an instruction-level model expands each instruction into
// per-cycle stimulus and expected outputs; a monitor compares every cycle.
module tb_multicycle_controller;
    import riscv_ctrl_pkg::*;

    localparam int TO = 16;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [6:0]    opcode = '0;
    logic          zero = 1'b0;
    logic          mem_ready = 1'b0;
    logic          mem_req, mem_we, ir_write, pc_write, pc_src, alu_src;
    logic          mem_to_reg, reg_write, retire, illegal, bus_error;
    logic [1:0]    alu_op;
    logic [2:0]    state;
    logic [RW-1:0] retired;

    multicycle_controller #(.MEM_TIMEOUT(TO), .RETIRE_W(RW)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .alu_src    (alu_src),
        .mem_to_reg (mem_to_reg),
        .reg_write  (reg_write),
        .retire     (retire),
        .illegal    (illegal),
        .bus_error  (bus_error),
        .alu_op     (alu_op),
        .state      (state),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]    st;
        logic          mem_req, mem_we, ir_write, pc_write, pc_src, alu_src;
        logic          mem_to_reg, reg_write, retire, illegal, bus_error;
        logic [1:0]    alu_op;
        logic [RW-1:0] retired;
    } obs_t;

    typedef struct packed {
        logic       rst;
        logic       mr;
        logic       z;
        logic [6:0] op;
    } stim_t;

    stim_t stim_q[$];
    obs_t  exp_q[$];
    int    ret_cnt = 0;
    bit    ill_pend = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    int    drv_cnt = 0;
    int    chk_cnt = 0;
    bit    go = 0;

    function automatic obs_t blank(input logic [2:0] st);
        obs_t o;
        o    = '0;
        o.st = st;
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    function automatic logic [6:0] ro();
        return 7'($urandom);
    endfunction

    task automatic push(input obs_t e, input logic mr, input logic z, input logic [6:0] op);
        stim_t s;
        if (ill_pend) begin
            e.illegal = 1'b1;
            ill_pend  = 1'b0;
        end
        e.retired = RW'(ret_cnt);
        s = '{rst: 1'b0, mr: mr, z: z, op: op};
        stim_q.push_back(s);
        exp_q.push_back(e);
        if (e.retire) ret_cnt = (ret_cnt + 1) % (1 << RW);
    endtask

    task automatic add_reset(input int n);
        stim_t s;
        ill_pend = 1'b0;
        ret_cnt  = 0;
        for (int i = 0; i < n; i++) begin
            s = '{rst: 1'b1, mr: rb(), z: rb(), op: ro()};
            stim_q.push_back(s);
            exp_q.push_back(blank(3'd0));
        end
    endtask

    // One memory phase in state st; returns 1 if it completed, 0 on timeout.
    task automatic mem_phase(input logic [2:0] st, input logic we, input int waits,
                             input obs_t done_vec, output bit ok);
        obs_t e;
        int   n;
        n = (waits >= TO) ? TO : waits;
        for (int i = 0; i < n; i++) begin
            e           = blank(st);
            e.mem_req   = 1'b1;
            e.mem_we    = we;
            e.bus_error = (i == TO - 1);
            push(e, 1'b0, rb(), ro());
        end
        if (waits >= TO) begin
            push(blank(3'd0), rb(), rb(), ro());
            ok = 1'b0;
        end else begin
            push(done_vec, 1'b1, rb(), ro());
            ok = 1'b1;
        end
    endtask

    task automatic add_instr(input logic [6:0] op, input logic z, input int fw, input int mw);
        obs_t e;
        bit   ok;
        bit   to_mem, to_wb;
        e          = blank(3'd0);
        e.mem_req  = 1'b1;
        e.ir_write = 1'b1;
        e.pc_write = 1'b1;
        mem_phase(3'd0, 1'b0, fw, e, ok);
        if (!ok) return;
        push(blank(3'd1), rb(), rb(), op);
        to_mem = 1'b0;
        to_wb  = 1'b0;
        e      = blank(3'd2);
        case (op)
            OpR:    begin e.alu_op = 2'b10; to_wb = 1'b1; end
            OpIalu: begin e.alu_src = 1'b1; to_wb = 1'b1; end
            OpLoad, OpStore: begin e.alu_src = 1'b1; to_mem = 1'b1; end
            OpBranch: begin
                e.alu_op   = 2'b01;
                e.pc_write = z;
                e.pc_src   = 1'b1;
                e.retire   = 1'b1;
            end
            OpJal, OpJalr: begin
                e.alu_src  = 1'b1;
                e.pc_write = 1'b1;
                e.pc_src   = 1'b1;
                to_wb      = 1'b1;
            end
            default: begin
                ill_pend = 1'b1;
                return;
            end
        endcase
        push(e, rb(), z, ro());
        if (to_mem) begin
            e         = blank(3'd3);
            e.mem_req = 1'b1;
            e.mem_we  = (op == OpStore);
            e.retire  = (op == OpStore);
            mem_phase(3'd3, op == OpStore, mw, e, ok);
            if (!ok || op == OpStore) return;
            to_wb = 1'b1;
        end
        if (to_wb) begin
            e            = blank(3'd4);
            e.reg_write  = 1'b1;
            e.mem_to_reg = (op == OpLoad);
            e.retire     = 1'b1;
            push(e, rb(), rb(), ro());
        end
    endtask

    function automatic int pick_wait();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) return r % 4;
        return 12 + r;
    endfunction

    function automatic logic [6:0] pick_op();
        logic [6:0] ops [8];
        ops = '{OpR, OpLoad, OpStore, OpIalu, OpBranch, OpJal, OpJalr, 7'b1111111};
        return ops[$urandom_range(0, 7)];
    endfunction

    always @(posedge clk) begin
        if (go && stim_q.size() > 0) begin
            stim_t s;
            #1;
            s         = stim_q.pop_front();
            reset     = s.rst;
            mem_ready = s.mr;
            zero      = s.z;
            opcode    = s.op;
            drv_cnt++;
        end
    end

    always @(negedge clk) begin
        if (drv_cnt > chk_cnt) begin
            obs_t e, got;
            e   = exp_q.pop_front();
            got = '{st: state, mem_req: mem_req, mem_we: mem_we, ir_write: ir_write,
                    pc_write: pc_write, pc_src: pc_src, alu_src: alu_src,
                    mem_to_reg: mem_to_reg, reg_write: reg_write, retire: retire,
                    illegal: illegal, bus_error: bus_error, alu_op: alu_op,
                    retired: retired};
            n_tests++;
            if (got !== e) begin
                n_fail++;
                $display("FAIL cycle_%0d outputs: got %p, expected %p", chk_cnt, got, e);
            end
            chk_cnt++;
        end
    end

    initial begin
        int total;
        add_reset(3);
        add_instr(OpR, 1'b0, 0, 0);
        add_instr(OpLoad, 1'b0, 0, 3);
        add_instr(OpBranch, 1'b1, 0, 0);
        add_instr(OpBranch, 1'b0, 0, 0);
        add_instr(7'b1111111, 1'b0, 0, 0);
        add_instr(OpR, 1'b0, TO, 0);
        add_instr(OpLoad, 1'b0, 0, TO - 1);
        add_instr(OpStore, 1'b0, 1, TO);
        add_reset(2);
        // Store aborted by reset two cycles into its memory wait
        add_instr(OpStore, 1'b0, 0, TO + 4);
        repeat (TO - 1) begin
            void'(stim_q.pop_back());
            void'(exp_q.pop_back());
        end
        add_reset(2);
        for (int i = 0; i < 160; i++) begin
            add_instr(pick_op(), rb(), pick_wait(), pick_wait());
        end
        add_reset(1);
        total = exp_q.size();
        go    = 1'b1;
        for (int i = 0; i < 50000 && chk_cnt < total; i++) @(posedge clk);
        if (chk_cnt < total) begin
            n_tests++;
            n_fail++;
            $display("FAIL run_timeout: checked %0d cycles, expected %0d", chk_cnt, total);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have parameter MEM_TIMEOUT, default 16: the maximum number of cycles to wait for mem_ready in one memory phase (legal range 2..255).
REQ-002 The block SHALL have parameter RETIRE_W, default 32: width of the retired-instruction counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port opcode, input, 7 bits: instruction[6:0] from the instruction register, sampled in DECODE.
REQ-006 The block SHALL have port zero, input, 1 bit: ALU branch-condition result, sampled in EXECUTE.
REQ-007 The block SHALL have port mem_ready, input, 1 bit: the memory completes the current access this cycle.
REQ-008 The block SHALL have these outputs, 1 bit each: mem_req, mem_we, ir_write, pc_write, pc_src (0 = PC+4, 1 = ALU target), alu_src, mem_to_reg, reg_write, retire, illegal, bus_error.
REQ-009 The block SHALL have output alu_op, 2 bits: 00 = add, 01 = branch compare, 10 = funct-decoded.
REQ-010 The block SHALL have output state, 3 bits: the current FSM state, for debug.
REQ-011 The block SHALL have output retired, RETIRE_W bits: the count of completed instructions.

Function
REQ-012 The FSM SHALL have exactly these states: FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4. Codes 5-7 are unreachable and SHALL go to FETCH.
REQ-013 FETCH SHALL assert mem_req=1 and mem_we=0. On mem_ready=1, ir_write=1 and pc_write=1 (pc_src=0) for that cycle only, and the next state is DECODE; otherwise it stays in FETCH.
REQ-014 DECODE SHALL latch the opcode into an internal class register, with classes R (0110011), LOAD (0000011), STORE (0100011), IALU (0010011), BRANCH (1100011), JAL (1101111) and JALR (1100111).
REQ-015 In DECODE, any other opcode SHALL pulse illegal=1 for one cycle and go to FETCH without retiring.
REQ-016 In EXECUTE, class R SHALL give alu_op=10, alu_src=0, then WRITEBACK.
REQ-017 In EXECUTE, classes IALU, LOAD and STORE SHALL give alu_op=00, alu_src=1, then WRITEBACK (IALU) or MEMORY (LOAD, STORE).
REQ-018 In EXECUTE, class BRANCH SHALL give alu_op=01, alu_src=0, pc_write=zero, pc_src=1, retire=1, then FETCH.
REQ-019 In EXECUTE, classes JAL and JALR SHALL give alu_op=00, alu_src=1, pc_write=1, pc_src=1, then WRITEBACK.
REQ-020 MEMORY SHALL assert mem_req=1, with mem_we=1 only for STORE. On mem_ready=1, LOAD goes to WRITEBACK and STORE pulses retire=1 and goes to FETCH.
REQ-021 WRITEBACK SHALL assert reg_write=1 for one cycle, with mem_to_reg=1 only for LOAD, pulse retire=1, and go to FETCH.
REQ-022 A wait counter SHALL clear on entry to FETCH or MEMORY and increment each cycle that mem_req=1 and mem_ready=0.
REQ-023 When the wait counter reaches MEM_TIMEOUT-1 with mem_ready=0, the block SHALL pulse bus_error=1 for one cycle, drop mem_req the next cycle, and go to FETCH with no retire, pc_write or ir_write.
REQ-024 If mem_ready=1 in the same cycle as the timeout, mem_ready SHALL win and bus_error SHALL stay 0.
REQ-025 mem_ready SHALL be ignored in DECODE, EXECUTE and WRITEBACK.
REQ-026 The retired counter SHALL increment by 1 on each retire pulse and wrap modulo 2^RETIRE_W.
REQ-027 All outputs not listed for a state SHALL be 0 in that state. Outputs SHALL be decoded from the registered state plus mem_ready, zero and the class register only, with no combinational path from opcode.
REQ-028 Instruction latency with zero wait states SHALL be: BRANCH 3 cycles, SW 4, R, IALU, JAL and JALR 4, LW 5. Each cycle of mem_ready=0 adds one cycle.

Reset
REQ-029 While reset=1, state SHALL be FETCH; the class register, wait counter and retired SHALL be 0; and all outputs except state SHALL be forced to 0, including mem_req.
REQ-030 Reset asserted mid-access SHALL abort the access: mem_req=0 in the reset cycle, no retire, and no pc_write.
REQ-031 The first mem_req=1 SHALL occur in the first cycle after reset deasserts.

Structure
REQ-032 Package riscv_ctrl_pkg SHALL hold the state encodings, the seven opcode constants, the instruction-class encoding and the alu_op encodings.
REQ-033 The opcode-to-class mapping, including the illegal flag, SHALL be a combinational sub-module opcode_classifier instantiated once.
REQ-034 The FSM, wait counter and retired counter SHALL live in multicycle_controller.

Verification
REQ-035 Reset scenario: hold reset 3 cycles with mem_ready=1, then release -> all outputs 0 during reset; mem_req=1 in the first cycle after release; state=0.
REQ-036 R-type scenario: opcode=0110011, mem_ready=1 always -> state sequence 0,1,2,4,0; reg_write=1 exactly once; retired 0->1 after 4 cycles.
REQ-037 Load scenario: opcode=0000011 with mem_ready held 0 for 3 cycles in MEMORY -> 8 cycles total; mem_to_reg=1 and reg_write=1 in WRITEBACK; mem_we=0 throughout.
REQ-038 Branch scenario: opcode=1100011 run once with zero=1 and once with zero=0 -> pc_write=1 with pc_src=1 in EXECUTE only when zero=1; retire=1 both times; no reg_write.
REQ-039 Illegal and timeout scenario: opcode=1111111 -> illegal pulses in DECODE and retired is unchanged; then mem_ready=0 for 16 cycles in FETCH -> bus_error pulses on the 16th cycle and state returns to FETCH with the counter cleared.
REQ-040 Mid-access reset scenario: assert reset during a SW MEMORY wait -> mem_req and mem_we are 0 the same cycle; after release state=0 and retired is unchanged from 0.
